// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM encoding and memory geometry for the load/store unit
package mem_pkg;
   localparam int MEM_DEPTH  = 32;
   localparam int MEM_WORD_W = 32;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;
endpackage

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store initiator sequencing the mem array pins
module mem_lsu
   import mem_pkg::*;
#(
   parameter int DEPTH = MEM_DEPTH,
   parameter int WAIT  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [MEM_WORD_W-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [MEM_WORD_W-1:0] resp_rdata,
   output logic                  resp_err,
   output logic [31:0]           ADDR,
   output logic [MEM_WORD_W-1:0] DIN,
   output logic                  en_W,
   output logic                  en_R,
   input  logic [MEM_WORD_W-1:0] R
);
   localparam int CW = $clog2(WAIT + 1);
   state_t                r_state, w_state;
   logic [CW-1:0]         r_cnt, w_cnt;
   logic                  r_we, w_we, r_en_w, w_en_w, r_en_r, w_en_r;
   logic                  r_rv, w_rv, r_err, w_err, w_req_ready;
   logic [31:0]           r_addr, w_addr;
   logic [MEM_WORD_W-1:0] r_din, w_din, r_rdata, w_rdata;
   assign w_req_ready = (r_state == IDLE) & ~rst;
   assign req_ready   = w_req_ready;
   assign resp_valid  = r_rv;
   assign resp_err    = r_err;
   assign resp_rdata  = r_rdata;
   assign ADDR        = r_addr;
   assign DIN         = r_din;
   assign en_W        = r_en_w;
   assign en_R        = r_en_r;
   // next state and next register values; pins change only at phase boundaries so ADDR/DIN are stable under an enable
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_we    = r_we;
      w_en_w  = r_en_w;
      w_en_r  = r_en_r;
      w_rv    = r_rv;
      w_err   = r_err;
      w_addr  = r_addr;
      w_din   = r_din;
      w_rdata = r_rdata;
      case (r_state)
         IDLE: if (req_valid & w_req_ready) begin
            w_we = req_we;
            if (req_addr >= 32'(DEPTH)) begin
               w_state = RESP;
               w_rv    = 1'b1;
               w_err   = 1'b1;
            end else begin
               w_state = SETUP;
               w_addr  = req_addr;
               w_din   = req_we ? req_wdata : '0;
            end
         end
         SETUP: begin
            w_state = ACCESS;
            w_cnt   = CW'(WAIT);
            w_en_w  = r_we;
            w_en_r  = ~r_we;
         end
         ACCESS: if (r_cnt == CW'(1)) begin
            w_state = RESP;
            w_en_w  = 1'b0;
            w_en_r  = 1'b0;
            w_rv    = 1'b1;
            w_rdata = r_we ? r_rdata : R;
         end else begin
            w_cnt = r_cnt - CW'(1);
         end
         RESP: if (resp_ready) begin
            w_state = IDLE;
            w_rv    = 1'b0;
            w_err   = 1'b0;
            w_rdata = '0;
         end
         default: w_state = IDLE;
      endcase
   end
   // state and registered outputs; reset drops the enables at once and discards any in-flight transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_en_w  <= 1'b0;
         r_en_r  <= 1'b0;
         r_rv    <= 1'b0;
         r_err   <= 1'b0;
         r_addr  <= '0;
         r_din   <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_state;
         r_cnt   <= w_cnt;
         r_we    <= w_we;
         r_en_w  <= w_en_w;
         r_en_r  <= w_en_r;
         r_rv    <= w_rv;
         r_err   <= w_err;
         r_addr  <= w_addr;
         r_din   <= w_din;
         r_rdata <= w_rdata;
      end
   end
endmodule
